// File: rtl/ahb_cmd_master.sv
// AHB-lite style command master: queues local read/write commands in a small FIFO
// and issues them as pipelined address/data-phase transfers, returning read data on a strobe.
module ahb_cmd_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [WORD_WIDTH-1:0] cmd_wdata,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic                  hwrite,
    output logic [1:0]            htrans,
    output logic [WORD_WIDTH-1:0] hwdata,
    input  logic [WORD_WIDTH-1:0] hrdata,
    input  logic                  hready,
    output logic                  rsp_valid,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  busy
);

    // Command port: a command is taken on any edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on FIFO fullness, never on cmd_valid or hready.

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CMD_W = 1 + ADDR_WIDTH + WORD_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CMD_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [WORD_WIDTH-1:0] head_wdata;

    logic                  ap_valid;
    logic [WORD_WIDTH-1:0] ap_wdata;
    logic                  dp_valid;
    logic                  dp_write;
    logic [ADDR_WIDTH-1:0] dp_addr;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign {head_write, head_addr, head_wdata} = fifo_mem[rptr];

    assign ap_valid = (state == ST_RUN);
    assign busy     = !empty || ap_valid || dp_valid;

    always_ff @(posedge hclk) begin
        if (push) begin
            fifo_mem[wptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The whole pipeline advances only when the slave signals hready.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        if (hready) begin
            pop = !empty;
            if (!empty) begin
                state_next = ST_RUN;
            end else if (state == ST_RUN) begin
                state_next = ST_DRAIN;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    // haddr/hwrite are the address-phase registers; hwdata is the data-phase write data.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            haddr     <= '0;
            hwrite    <= 1'b0;
            htrans    <= HTRANS_IDLE;
            ap_wdata  <= '0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_addr   <= '0;
            hwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_addr  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (hready) begin
                if (dp_valid && !dp_write) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= hrdata;
                    rsp_addr  <= dp_addr;
                end
                dp_valid <= ap_valid;
                dp_write <= hwrite;
                dp_addr  <= haddr;
                if (ap_valid && hwrite) begin
                    hwdata <= ap_wdata;
                end
                if (pop) begin
                    haddr    <= head_addr;
                    hwrite   <= head_write;
                    ap_wdata <= head_wdata;
                    htrans   <= HTRANS_NONSEQ;
                end else begin
                    hwrite <= 1'b0;
                    htrans <= HTRANS_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: SRAM-like slave model, reference memory and read-response scoreboard.
module tb_ahb_cmd_master;

    localparam int AW = 4;
    localparam int WW = 8;

    logic          hclk;
    logic          hresetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [WW-1:0] cmd_wdata;
    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [1:0]    htrans;
    logic [WW-1:0] hwdata;
    logic [WW-1:0] hrdata;
    logic          hready;
    logic          rsp_valid;
    logic [WW-1:0] rsp_rdata;
    logic [AW-1:0] rsp_addr;
    logic          busy;

    int n_checks = 0;
    int n_fails  = 0;

    logic [AW+WW-1:0] exp_q[$];
    logic [WW-1:0]    ref_mem [16];

    logic          s_dp_valid;
    logic          s_dp_write;
    logic [AW-1:0] s_dp_addr;
    logic [WW-1:0] smem [16];

    ahb_cmd_master #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .FIFO_DEPTH(4)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_addr  (rsp_addr),
        .busy      (busy)
    );

    // clock / reset
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // slave model: tracks its own data phase from the bus
    assign hrdata = s_dp_valid ? smem[s_dp_addr] : '0;

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            s_dp_valid <= 1'b0;
            s_dp_write <= 1'b0;
            s_dp_addr  <= '0;
        end else if (hready) begin
            if (s_dp_valid && s_dp_write) smem[s_dp_addr] <= hwdata;
            s_dp_valid <= (htrans == 2'b10);
            s_dp_write <= hwrite;
            s_dp_addr  <= haddr;
        end
    end

    // scoreboard: compare every response with the oldest expected read
    always @(negedge hclk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                logic [AW+WW-1:0] e;
                e = exp_q.pop_front();
                check("rsp_addr", 32'(rsp_addr), 32'(e[AW+WW-1:WW]));
                check("rsp_rdata", 32'(rsp_rdata), 32'(e[WW-1:0]));
            end
        end
    end

    // driver tasks
    task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [WW-1:0] d);
        int waited;
        @(negedge hclk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge hclk);
            waited++;
        end
        if (!cmd_ready) begin
            check("push_timeout", 32'(cmd_ready), 32'd1);
        end else begin
            @(posedge hclk);
            if (w) ref_mem[a] = d;
            else   exp_q.push_back({a, ref_mem[a]});
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        @(negedge hclk);
        while (busy && cyc < 100) begin
            @(negedge hclk);
            cyc++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_htrans"}, 32'(htrans), 32'd0);
        check({tag, "_haddr"}, 32'(haddr), 32'd0);
        check({tag, "_hwrite"}, 32'(hwrite), 32'd0);
        check({tag, "_hwdata"}, 32'(hwdata), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        check({tag, "_rsp_addr"}, 32'(rsp_addr), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int run_len;
        int max_run;
        hresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        hready    = 1'b1;
        repeat (3) @(negedge hclk);
        check_reset_outputs("rst");
        hresetn = 1'b1;

        // single write then read, latency and pulse width
        @(negedge hclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h3; cmd_wdata = 8'h5A;
        ref_mem[3] = 8'h5A;
        @(negedge hclk);
        check("t1_ap_not_yet", 32'(htrans), 32'd0);
        cmd_write = 1'b0;
        exp_q.push_back({4'h3, ref_mem[3]});
        @(negedge hclk);
        cmd_valid = 1'b0;
        check("t1_wr_htrans", 32'(htrans), 32'h2);
        check("t1_wr_haddr", 32'(haddr), 32'h3);
        check("t1_wr_hwrite", 32'(hwrite), 32'd1);
        @(negedge hclk);
        check("t1_rd_htrans", 32'(htrans), 32'h2);
        check("t1_rd_hwrite", 32'(hwrite), 32'd0);
        check("t1_hwdata", 32'(hwdata), 32'h5A);
        check("t1_no_rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge hclk);
        check("t1_idle_htrans", 32'(htrans), 32'd0);
        check("t1_no_wr_rsp", 32'(rsp_valid), 32'd0);
        @(negedge hclk);
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_rdata", 32'(rsp_rdata), 32'h5A);
        @(negedge hclk);
        check("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);

        // back-to-back writes and reads without bubbles
        max_run = 0;
        run_len = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) push_cmd(1'b1, AW'(i), WW'(8'h10 + i));
                for (int i = 0; i < 4; i++) push_cmd(1'b0, AW'(i), '0);
            end
            begin
                repeat (14) begin
                    @(negedge hclk);
                    run_len = (htrans == 2'b10) ? run_len + 1 : 0;
                    if (run_len > max_run) max_run = run_len;
                end
            end
        join
        check("t2_nonseq_run", 32'(max_run), 32'd8);
        wait_idle();

        // stall during a read data phase
        push_cmd(1'b0, 4'h2, '0);
        @(negedge hclk);
        @(negedge hclk);
        check("t3_ap", 32'(htrans), 32'h2);
        @(negedge hclk);
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            check("t3_htrans", 32'(htrans), 32'd0);
            check("t3_haddr", 32'(haddr), 32'h2);
            check("t3_hwrite", 32'(hwrite), 32'd0);
            check("t3_hwdata", 32'(hwdata), 32'h13);
            check("t3_rsp_stall", 32'(rsp_valid), 32'd0);
        end
        hready = 1'b1;
        @(negedge hclk);
        check("t3_rsp_after", 32'(rsp_valid), 32'd1);
        wait_idle();

        // fill FIFO while the slave stalls
        hready = 1'b0;
        push_cmd(1'b1, 4'h8, 8'hA8);
        push_cmd(1'b1, 4'h9, 8'hA9);
        push_cmd(1'b0, 4'h8, '0);
        push_cmd(1'b1, 4'h8, 8'hB8);
        @(negedge hclk);
        check("t4_full_ready", 32'(cmd_ready), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_no_issue", 32'(htrans), 32'd0);
        fork
            push_cmd(1'b0, 4'h8, '0);
            begin
                repeat (2) begin
                    @(negedge hclk);
                    check("t4_held", 32'(cmd_ready), 32'd0);
                end
                hready = 1'b1;
            end
        join
        wait_idle();

        // reset between a read's address and data phase
        push_cmd(1'b0, 4'h1, '0);
        @(negedge hclk);
        @(negedge hclk);
        check("t5_ap", 32'(htrans), 32'h2);
        hresetn = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("t5");
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        repeat (4) begin
            @(negedge hclk);
            check("t5_no_rsp", 32'(rsp_valid), 32'd0);
        end
        push_cmd(1'b0, 4'h1, '0);
        wait_idle();

        // idle bus
        repeat (6) begin
            @(negedge hclk);
            check("t6_htrans", 32'(htrans), 32'd0);
            check("t6_hwrite", 32'(hwrite), 32'd0);
            check("t6_busy", 32'(busy), 32'd0);
            check("t6_rsp", 32'(rsp_valid), 32'd0);
        end

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ahb_cmd_master.md
Name: ahb_cmd_master

Overview:
- Upstream AHB-lite style master that drives the sram_controller bus: haddr, hwrite, hwdata, and reads hrdata/hready.
- Accepts read/write commands from a local valid/ready port into a small command FIFO.
- Issues them as pipelined AHB transfers: address phase, then data phase, with hready-driven stalls.
- Returns read data on a one-cycle response strobe.

Parameters:
ADDR_WIDTH, 4, bus/SRAM address width
WORD_WIDTH, 8, data word width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)

Ports:
hclk  input  1  bus clock, all state on rising edge
hresetn  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept (= !full)
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH  command address
cmd_wdata  input  WORD_WIDTH  write data (ignored for reads)
haddr  output  ADDR_WIDTH  address-phase address (registered)
hwrite  output  1  address-phase direction (registered)
htrans  output  2  2'b00 IDLE, 2'b10 NONSEQ (registered)
hwdata  output  WORD_WIDTH  data-phase write data (registered)
hrdata  input  WORD_WIDTH  data-phase read data from slave
hready  input  1  slave ready; 0 stalls both phases
rsp_valid  output  1  one-cycle pulse, read data valid
rsp_rdata  output  WORD_WIDTH  captured read data
rsp_addr  output  ADDR_WIDTH  address of returned read
busy  output  1  FIFO non-empty or any phase outstanding

Behaviour:
- Reset (hresetn=0, async): FIFO emptied, haddr=0, hwrite=0, htrans=IDLE, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_addr=0, busy=0, cmd_ready=1. All outputs hold reset values until the first rising hclk after deassertion.
- FIFO push on edge when cmd_valid && cmd_ready.
- cmd_ready is !full only. A pop in the same cycle does not open a slot when full.
- Push into an empty FIFO becomes visible to the issue logic on the next edge (1-cycle FIFO latency).
- Phase registers:
  - AP (address phase): valid, write, addr, wdata.
  - DP (data phase): valid, write, addr, wdata.
- States, decoded from AP/DP valid:
  - IDLE: AP=0, DP=0.
  - RUN: AP=1.
  - DRAIN: AP=0, DP=1.
- Advance rule, on each edge with hready=1:
  - DP completes.
  - AP moves to DP.
  - If FIFO non-empty, pop head into AP; otherwise AP=0.
- Edge with hready=0: AP, DP, FIFO read pointer and all bus outputs hold; pushes still accepted.
- Bus outputs:
  - AP valid: htrans=NONSEQ, haddr/hwrite from AP.
  - AP invalid: htrans=IDLE, hwrite=0, haddr holds last value.
  - hwdata = DP.wdata when DP valid write, else holds.
- Read completion: edge with hready=1 and DP valid read → rsp_rdata<=hrdata, rsp_addr<=DP.addr, rsp_valid<=1 for exactly one cycle.
- Write completion produces no response.
- Latency, empty/idle, hready=1 throughout, push at edge N:
  - AP (haddr/htrans) driven after N+1.
  - DP (hwdata) after N+2.
  - Read response (rsp_valid) after N+3.
- Throughput: one transfer per cycle back-to-back; no bubble between consecutive commands.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Occupancy counter width is clog2(FIFO_DEPTH)+1.
- busy = FIFO non-empty | AP valid | DP valid.
- Reset mid-transfer drops in-flight AP/DP and queued commands; no rsp_valid is generated for dropped reads.

Test Plan:
- Write 0x5A to addr 0x3, then read addr 0x3, hready=1 → htrans NONSEQ for 2 consecutive cycles; hwdata=0x5A one cycle after the write address; rsp_valid single pulse with rsp_rdata=0x5A, rsp_addr=0x3, 3 cycles after read push.
- 4 back-to-back writes (addr 0..3, data 0x10..0x13) then reads 0..3 → no IDLE gaps on htrans; 4 rsp pulses in order returning 0x10..0x13.
- Hold hready=0 for 3 cycles during a read data phase → haddr/hwrite/htrans/hwdata stable throughout; rsp_valid only after hready returns to 1, with the correct data.
- Push 5 commands with hready=0 → cmd_ready deasserts after 4 accepted; 5th held until first pop; all 5 execute in order after hready=1.
- Assert hresetn=0 between a read's address and data phase → all outputs to reset values immediately; no rsp_valid; busy=0; a new command after release executes normally.
- Idle with no commands → htrans=IDLE, hwrite=0, busy=0, rsp_valid never asserted.
